// File: rtl/count_bcd_converter.sv
// Serial double-dabble converter from a binary count to packed BCD digits.
// Optional leading-zero mask output enabled by COUNT_BCD_LEADING_ZERO_BLANK_EN.
module count_bcd_converter #(
  parameter int C_bits   = 32,
  parameter int C_digits = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [C_bits-1:0]       bin_in,
  input  logic                    refresh,
  output logic                    busy,
  output logic [4*C_digits-1:0]   bcd_out,
  output logic                    bcd_valid
`ifdef COUNT_BCD_LEADING_ZERO_BLANK_EN
  ,
  output logic [C_digits-1:0]     digit_blank
`endif
);

  localparam int CW = $clog2(C_bits + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(C_bits - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]            state;
  logic [C_bits-1:0]     last_value;
  logic [C_bits-1:0]     sr;
  logic [4*C_digits-1:0] acc;
  logic [4*C_digits-1:0] adj;
  logic [CW-1:0]         cnt;
  logic                  start;

  // Requests arriving while busy are not latched; the compare against
  // last_value on return to IDLE picks up whatever value is current then.
  assign start = (bin_in != last_value) || refresh;
  assign busy  = (state == SHIFT) || (state == DONE);

  always_comb begin
    adj = acc;
    for (int i = 0; i < C_digits; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bcd_valid  <= 1'b0;
      bcd_out    <= '0;
      last_value <= '0;
      sr         <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr         <= bin_in;
            last_value <= bin_in;
            acc        <= '0;
            cnt        <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Overflow out of the accumulator MSB falls off the shift.
          {acc, sr} <= {adj, sr} << 1;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_out   <= acc;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COUNT_BCD_LEADING_ZERO_BLANK_EN
  logic [C_digits-1:0] blank_next;
  logic                higher_nz;

  // Digit 0 is never blanked so a zero count still shows one "0".
  always_comb begin
    blank_next = '1;
    higher_nz  = 1'b0;
    for (int k = C_digits - 1; k >= 1; k--) begin
      higher_nz     = higher_nz | (acc[4*k +: 4] != 4'd0);
      blank_next[k] = ~higher_nz;
    end
    blank_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_blank <= {{(C_digits-1){1'b1}}, 1'b0};
    end else if (state == DONE) begin
      digit_blank <= blank_next;
    end
  end
`endif

endmodule
